symbol_packer: RTL and testbench

- Parametrised symbol-to-word packer: gathers PQ_SYMBOLS narrow symbols of SYM_W bits each into one wide word, o_all_symbols.
- Successor to the fixed 4-bit all-symbols output. Adds generic symbol width, partial-word flush on last, and valid/ready back-pressure on both sides.
- Sits between a symbol-rate source (decoder/quantiser) and a word-wide consumer (FIFO or bus master) in the same clock domain.

---
 rtl/symbol_packer_pkg.sv | 20 ++
 rtl/symbol_packer_out_reg.sv | 47 ++++
 rtl/symbol_packer.sv | 106 ++++++++++
 tb/tb_symbol_packer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/symbol_packer_pkg.sv
// Shared types for the symbol packer: default geometry, count-width helper
// and the packed output word carried by the output register.
package symbol_pkg;

  localparam int PQ_SYMBOLS_DEF = 8;
  localparam int SYM_W_DEF      = 4;

  function automatic int clog2_count(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int COUNT_W_DEF = clog2_count(PQ_SYMBOLS_DEF);

  typedef struct packed {
    logic [PQ_SYMBOLS_DEF*SYM_W_DEF-1:0] data;
    logic [COUNT_W_DEF-1:0]              count;
    logic                                last;
  } pack_word_t;

endpackage

// File: rtl/symbol_packer_out_reg.sv
// One-entry valid/ready output register for packed words; loads when empty or
// draining in the same cycle, holds its word stable while downstream stalls.
module symbol_out_reg
  import symbol_pkg::*;
#(
  parameter type word_t = pack_word_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  word_t load_dat_i,
  output logic  load_rdy_o,
  output logic  vld_o,
  output word_t dat_o,
  input  logic  rdy_i
);

  logic  vld_q, vld_d;
  word_t dat_q, dat_d;

  assign load_rdy_o = !vld_q || rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load_i) begin
      vld_d = 1'b1;
      dat_d = load_dat_i;
    end else if (rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/symbol_packer.sv
// Packs PQ_SYMBOLS symbols of SYM_W bits into one word, flushing early on i_last;
// one-cycle latency, valid/ready both sides. SYMBOL_PACKER_MSB_FIRST_EN puts slot 0 in the MSBs.
module symbol_packer
  import symbol_pkg::*;
#(
  parameter int              PQ_SYMBOLS = PQ_SYMBOLS_DEF,
  parameter int              SYM_W      = SYM_W_DEF,
  parameter logic [SYM_W-1:0] PAD_VAL   = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_en,
  input  logic                                  i_valid,
  input  logic [SYM_W-1:0]                      i_symbol,
  input  logic                                  i_last,
  output logic                                  o_ready,
  output logic                                  o_valid,
  output logic [PQ_SYMBOLS*SYM_W-1:0]           o_all_symbols,
  output logic [clog2_count(PQ_SYMBOLS)-1:0]    o_count,
  output logic                                  o_last,
  input  logic                                  i_ready
);

  localparam int WORD_W  = PQ_SYMBOLS * SYM_W;
  localparam int COUNT_W = clog2_count(PQ_SYMBOLS);
  localparam int CNT_W   = $clog2(PQ_SYMBOLS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PQ_SYMBOLS - 1);
  localparam logic [WORD_W-1:0] PAD_WORD = {PQ_SYMBOLS{PAD_VAL}};

  typedef struct packed {
    logic [WORD_W-1:0]  data;
    logic [COUNT_W-1:0] count;
    logic               last;
  } word_t;

  function automatic int slot_lo(input logic [CNT_W-1:0] k);
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
    return (PQ_SYMBOLS - 1 - int'(k)) * SYM_W;
`else
    return int'(k) * SYM_W;
`endif
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d, asm_ins;
  logic              accept, emit, out_rdy;
  word_t             load_dat, out_dat;

  assign o_ready = !rst && i_en && out_rdy;
  assign accept  = i_valid && o_ready;
  // Counter wraps by explicit compare so non-power-of-two word sizes work.
  assign emit    = accept && ((cnt_q == CNT_LAST) || i_last);

  always_comb begin
    asm_ins = asm_q;
    asm_ins[slot_lo(cnt_q) +: SYM_W] = i_symbol;
  end

  always_comb begin
    load_dat.data  = asm_ins;
    load_dat.count = COUNT_W'(cnt_q) + COUNT_W'(1);
    load_dat.last  = i_last;
  end

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (accept) begin
      if (emit) begin
        cnt_d = '0;
        asm_d = PAD_WORD;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        asm_d = asm_ins;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= PAD_WORD;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  symbol_out_reg #(
    .word_t (word_t)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load_i     (emit),
    .load_dat_i (load_dat),
    .load_rdy_o (out_rdy),
    .vld_o      (o_valid),
    .dat_o      (out_dat),
    .rdy_i      (i_ready)
  );

  assign o_all_symbols = out_dat.data;
  assign o_count       = out_dat.count;
  assign o_last        = out_dat.last;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: 4x4 instance against a queue scoreboard,
// plus a 3x8 instance for non-power-of-two wrap and slot ordering.
module tb_symbol_packer;

  localparam int PQ = 4;
  localparam int SW = 4;
  localparam int WW = PQ * SW;
  localparam int CW = 3;

`ifdef SYMBOL_PACKER_MSB_FIRST_EN
  localparam logic [15:0] EXP_1234 = 16'h1234;
  localparam logic [15:0] EXP_AB   = 16'hAB00;
  localparam logic [15:0] EXP_5678 = 16'h5678;
  localparam logic [15:0] EXP_CDEF = 16'hCDEF;
  localparam logic [23:0] EXP_B3   = 24'h112233;
  localparam logic [23:0] EXP_B1   = 24'h440000;
  localparam logic [23:0] EXP_BW   = 24'h010203;
  localparam logic [23:0] EXP_B2   = 24'h040500;
`else
  localparam logic [15:0] EXP_1234 = 16'h4321;
  localparam logic [15:0] EXP_AB   = 16'h00BA;
  localparam logic [15:0] EXP_5678 = 16'h8765;
  localparam logic [15:0] EXP_CDEF = 16'hFEDC;
  localparam logic [23:0] EXP_B3   = 24'h332211;
  localparam logic [23:0] EXP_B1   = 24'h000044;
  localparam logic [23:0] EXP_BW   = 24'h030201;
  localparam logic [23:0] EXP_B2   = 24'h000504;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, vld, lst, rdy;
  logic [SW-1:0] sym;
  logic          o_ready, o_valid, o_last;
  logic [WW-1:0] o_all_symbols;
  logic [CW-1:0] o_count;

  logic          b_en, b_vld, b_lst, b_rdy;
  logic [7:0]    b_sym;
  logic          b_ordy, b_ovld, b_olast;
  logic [23:0]   b_data;
  logic [1:0]    b_cnt;

  symbol_packer #(.PQ_SYMBOLS(PQ), .SYM_W(SW), .PAD_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_valid(vld), .i_symbol(sym), .i_last(lst),
    .o_ready(o_ready), .o_valid(o_valid), .o_all_symbols(o_all_symbols),
    .o_count(o_count), .o_last(o_last), .i_ready(rdy)
  );

  symbol_packer #(.PQ_SYMBOLS(3), .SYM_W(8), .PAD_VAL(8'h00)) dut3 (
    .clk(clk), .rst(rst), .i_en(b_en), .i_valid(b_vld), .i_symbol(b_sym), .i_last(b_lst),
    .o_ready(b_ordy), .o_valid(b_ovld), .o_all_symbols(b_data),
    .o_count(b_cnt), .o_last(b_olast), .i_ready(b_rdy)
  );

  typedef struct {
    logic [WW-1:0] data;
    logic [CW-1:0] count;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            m_cnt  = 0;
  logic [WW-1:0] m_asm  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_lo(input int k);
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
    return (PQ - 1 - k) * SW;
`else
    return k * SW;
`endif
  endfunction

  // Checks the current outputs against the model, then advances one clock.
  task automatic cycle(output bit acc);
    bit m_vld, exp_rdy;
    #1;
    m_vld   = (sb.size() != 0);
    exp_rdy = !rst && en && (!m_vld || rdy);
    chk("o_ready", o_ready, exp_rdy);
    chk("o_valid", o_valid, m_vld);
    if (m_vld) begin
      chk("o_all_symbols", o_all_symbols, sb[0].data);
      chk("o_count", o_count, sb[0].count);
      chk("o_last", o_last, sb[0].last);
    end
    acc = vld && exp_rdy;
    if (rst) begin
      sb.delete();
      m_cnt = 0;
      m_asm = '0;
    end else begin
      if (m_vld && rdy) void'(sb.pop_front());
      if (acc) begin
        m_asm[slot_lo(m_cnt) +: SW] = sym;
        if (m_cnt == PQ - 1 || lst) begin
          sb.push_back('{m_asm, CW'(m_cnt + 1), lst});
          m_cnt = 0;
          m_asm = '0;
        end else begin
          m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    vld = 1'b0;
    lst = 1'b0;
    repeat (n) cycle(acc);
  endtask

  task automatic send(input logic [SW-1:0] s, input logic l);
    bit acc;
    int n;
    n   = 0;
    vld = 1'b1;
    sym = s;
    lst = l;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 40);
    chk("send_accepted", acc, 1);
    vld = 1'b0;
    lst = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] s, input logic l);
    b_vld = 1'b1;
    b_sym = s;
    b_lst = l;
    #1;
    chk("b_ready", b_ordy, 1);
    @(negedge clk);
    b_vld = 1'b0;
    b_lst = 1'b0;
  endtask

  initial begin
    bit acc;
    int idx;
    rst = 1'b1; en = 1'b1; vld = 1'b0; lst = 1'b0; rdy = 1'b1; sym = '0;
    b_en = 1'b1; b_vld = 1'b0; b_lst = 1'b0; b_rdy = 1'b1; b_sym = '0;
    @(negedge clk);
    idle(2);
    #1;
    chk("rst_data", o_all_symbols, 0);
    chk("rst_count", o_count, 0);
    chk("rst_last", o_last, 0);
    rst = 1'b0;

    for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
    #1;
    chk("word_1234", o_all_symbols, EXP_1234);
    chk("word_1234_count", o_count, 4);
    idle(2);

    send(4'hA, 1'b0);
    send(4'hB, 1'b1);
    #1;
    chk("word_ab", o_all_symbols, EXP_AB);
    chk("word_ab_count", o_count, 2);
    chk("word_ab_last", o_last, 1);
    idle(1);

    idx = 0;
    for (int t = 0; t < 30; t++) begin
      rdy = (t >= 8);
      vld = (idx < 8);
      sym = 4'(idx + 1);
      lst = 1'b0;
      cycle(acc);
      if (acc) idx++;
    end
    vld = 1'b0;
    chk("bp_all_accepted", idx, 8);

    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    en = 1'b0; vld = 1'b1; sym = 4'hF; lst = 1'b1;
    repeat (3) cycle(acc);
    en = 1'b1;
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    #1;
    chk("word_5678", o_all_symbols, EXP_5678);
    chk("word_5678_count", o_count, 4);
    idle(2);

    rdy = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
    idle(2);
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    #1;
    chk("rst_drops_word", o_valid, 0);
    rdy = 1'b1;

    send(4'h9, 1'b0);
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    idle(1);
    for (int i = 12; i <= 15; i++) send(4'(i), 1'b0);
    #1;
    chk("word_after_rst", o_all_symbols, EXP_CDEF);
    idle(2);

    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b1);
    idle(2);
    send(4'h7, 1'b1);
    idle(2);
    chk("sb_empty", sb.size(), 0);

    b_send(8'h11, 1'b0);
    b_send(8'h22, 1'b0);
    b_send(8'h33, 1'b1);
    #1;
    chk("b_valid", b_ovld, 1);
    chk("b_word3", b_data, EXP_B3);
    chk("b_word3_count", b_cnt, 3);
    chk("b_word3_last", b_olast, 1);
    b_send(8'h44, 1'b0 | 1'b1);
    #1;
    chk("b_word1", b_data, EXP_B1);
    chk("b_word1_count", b_cnt, 1);
    b_send(8'h01, 1'b0);
    b_send(8'h02, 1'b0);
    b_send(8'h03, 1'b0);
    #1;
    chk("b_wrap_word", b_data, EXP_BW);
    chk("b_wrap_last", b_olast, 0);
    b_send(8'h04, 1'b0);
    b_send(8'h05, 1'b1);
    #1;
    chk("b_after_wrap", b_data, EXP_B2);
    chk("b_after_wrap_count", b_cnt, 2);
    @(negedge clk);
    #1;
    chk("b_drained", b_ovld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
